// File: rtl/memory_access_unit.sv
// Segmented memory access unit: forms a wrapped physical address from segment and offset,
// runs a req/ack handshake with external memory and drives held read data onto the shared bus.
// Optional wait timeout is enabled by defining MAU_TIMEOUT_EN.
module memory_access_unit #(
    parameter int ADDR_W    = 20,
    parameter int SEG_SHIFT = 4
`ifdef MAU_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 255
`endif
) (
    input  logic              clk,
    input  logic              r,
    inout  wire  [15:0]       bus,
    input  logic [15:0]       so,
    input  logic [15:0]       mo,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              mdoe,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [15:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack
);

    // state | meaning
    // IDLE  | waiting for rd_req / wr_req
    // WAIT  | mem_req asserted, waiting for mem_ack
    // DONE  | single-cycle completion pulse
    // FAULT | wait timed out, returns to IDLE next cycle
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_busy;
    logic                r_done;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [15:0]         r_mem_wdata;
    logic [15:0]         r_rdata;
    logic                w_mem_req_nxt;
    logic                w_mem_we_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [15:0]         w_mem_wdata_nxt;
    logic [15:0]         w_rdata_nxt;
    logic [ADDR_W-1:0]   w_seg_ext;
    logic [ADDR_W-1:0]   w_phys_addr;

`ifdef MAU_TIMEOUT_EN
    localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT);
    logic                r_fault;
    logic                w_fault_nxt;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_nxt;
    logic [7:0]          w_cnt_inc;
    assign w_cnt_inc = r_cnt + 8'd1;
`endif

    // Carry out of the top address bit is dropped so the address wraps.
    assign w_seg_ext   = ADDR_W'(so);
    assign w_phys_addr = (w_seg_ext << SEG_SHIFT) + ADDR_W'(mo);

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
`ifdef MAU_TIMEOUT_EN
        w_fault_nxt     = r_fault;
        w_cnt_nxt       = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (rd_req || wr_req) begin
                    w_state_nxt    = S_WAIT;
                    w_mem_addr_nxt = w_phys_addr;
                    w_mem_we_nxt   = wr_req;
                    w_mem_req_nxt  = 1'b1;
                    if (wr_req) begin
                        w_mem_wdata_nxt = bus;
                    end
`ifdef MAU_TIMEOUT_EN
                    w_fault_nxt = 1'b0;
                    w_cnt_nxt   = 8'd0;
`endif
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    w_state_nxt   = S_DONE;
                    w_mem_req_nxt = 1'b0;
                    if (!r_mem_we) begin
                        w_rdata_nxt = mem_rdata;
                    end
                end
`ifdef MAU_TIMEOUT_EN
                // Timeout fires on the edge that would complete TIMEOUT unanswered wait cycles.
                else if (w_cnt_inc == L_TIMEOUT) begin
                    w_state_nxt   = S_FAULT;
                    w_mem_req_nxt = 1'b0;
                    w_fault_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
`endif
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_FAULT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
`ifdef MAU_TIMEOUT_EN
            r_fault     <= 1'b0;
            r_cnt       <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
`ifdef MAU_TIMEOUT_EN
            r_fault     <= w_fault_nxt;
            r_cnt       <= w_cnt_nxt;
`endif
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;
`ifdef MAU_TIMEOUT_EN
    assign fault     = r_fault;
`else
    assign fault     = 1'b0;
`endif

    // Bus is released while in reset so it never fights other drivers.
    assign bus = (mdoe && r) ? r_rdata : 16'hzzzz;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit; timeout scenario runs only when MAU_TIMEOUT_EN is defined.
module tb_memory_access_unit;

    logic        clk;
    logic        r;
    wire  [15:0] bus;
    logic [15:0] so;
    logic [15:0] mo;
    logic        rd_req;
    logic        wr_req;
    logic        mdoe;
    logic        busy;
    logic        done;
    logic        fault;
    logic [15:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    logic        tb_drv_en;
    logic [15:0] tb_drv;
    int          n_tests;
    int          n_fail;
    int          n_done;
    int          done_base;
    int          req_hi;

    assign bus = tb_drv_en ? tb_drv : 16'hzzzz;

    memory_access_unit #(
        .ADDR_W(20),
        .SEG_SHIFT(4)
`ifdef MAU_TIMEOUT_EN
        ,
        .TIMEOUT(4)
`endif
    ) dut (
        .clk(clk), .r(r), .bus(bus), .so(so), .mo(mo),
        .rd_req(rd_req), .wr_req(wr_req), .mdoe(mdoe),
        .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) n_done++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_done = 0;
        r = 1'b0; so = '0; mo = '0; rd_req = 0; wr_req = 0; mdoe = 0;
        mem_rdata = '0; mem_ack = 0; tb_drv_en = 0; tb_drv = '0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_rdata", rdata, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        r = 1'b1;
        tick();

        // 1: read with minimum latency
        done_base = n_done;
        so = 16'h1234; mo = 16'h0010; rd_req = 1;
        tick();
        rd_req = 0;
        check("t1_req", mem_req, 1);
        check("t1_busy", busy, 1);
        check("t1_addr", mem_addr, 20'h12350);
        check("t1_we", mem_we, 0);
        check("t1_done_early", done, 0);
        mem_ack = 1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 0;
        check("t1_req_drop", mem_req, 0);
        check("t1_done", done, 1);
        check("t1_busy_done", busy, 1);
        check("t1_rdata", rdata, 16'hBEEF);
        tick();
        check("t1_done_end", done, 0);
        check("t1_busy_end", busy, 0);
        check("t1_ndone", n_done - done_base, 1);

        // 2: write, ack on the fourth wait edge
        tb_drv_en = 1; tb_drv = 16'hA55A;
        so = 16'h0100; mo = 16'h0002; wr_req = 1;
        tick();
        wr_req = 0; tb_drv = 16'h1111;
        check("t2_addr", mem_addr, 20'h01002);
        check("t2_we", mem_we, 1);
        check("t2_wdata", mem_wdata, 16'hA55A);
        req_hi = 0;
        mem_rdata = 16'h7777;
        for (int i = 0; i < 4; i++) begin
            if (mem_req) req_hi++;
            mem_ack = (i == 3);
            tick();
        end
        mem_ack = 0;
        check("t2_req_cycles", req_hi, 4);
        check("t2_req_drop", mem_req, 0);
        check("t2_done", done, 1);
        check("t2_wdata_stable", mem_wdata, 16'hA55A);
        check("t2_rdata_keep", rdata, 16'hBEEF);
        tick();
        tb_drv_en = 0;

        // 3: address wrap
        so = 16'hFFFF; mo = 16'h0020; rd_req = 1;
        tick();
        rd_req = 0;
        check("t3_addr_wrap", mem_addr, 20'h00010);
        mem_ack = 1; mem_rdata = 16'h1357;
        tick();
        mem_ack = 0;
        check("t3_rdata", rdata, 16'h1357);
        tick();

        // 4: simultaneous requests, request during WAIT, ack outside WAIT
        done_base = n_done;
        tb_drv_en = 1; tb_drv = 16'h00C3;
        so = 16'h0000; mo = 16'h0005; rd_req = 1; wr_req = 1;
        tick();
        rd_req = 0; wr_req = 0; tb_drv_en = 0;
        check("t4_we", mem_we, 1);
        check("t4_wdata", mem_wdata, 16'h00C3);
        check("t4_addr", mem_addr, 20'h00005);
        so = 16'h0F00; rd_req = 1;
        tick();
        rd_req = 0;
        check("t4_addr_hold", mem_addr, 20'h00005);
        check("t4_we_hold", mem_we, 1);
        mem_ack = 1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 0;
        tick(); tick(); tick();
        check("t4_ndone", n_done - done_base, 1);
        check("t4_rdata_keep", rdata, 16'h1357);
        check("t4_idle", busy, 0);
        mem_ack = 1;
        tick(); tick();
        mem_ack = 0;
        check("t4_stray_ack_busy", busy, 0);
        check("t4_stray_ack_done", n_done - done_base, 1);

        // 5: asynchronous reset during WAIT
        so = 16'h0002; mo = 16'h0003; rd_req = 1;
        tick();
        rd_req = 0;
        check("t5_req_pre", mem_req, 1);
        #2 r = 1'b0;
        #1;
        check("t5_req_async", mem_req, 0);
        check("t5_busy_async", busy, 0);
        check("t5_done_async", done, 0);
        check("t5_addr_async", mem_addr, 0);
        #2 r = 1'b1;
        tick();
        check("t5_idle", busy, 0);
        done_base = n_done;
        so = 16'h0010; mo = 16'h0001; rd_req = 1;
        tick();
        rd_req = 0;
        check("t5_addr", mem_addr, 20'h00101);
        mem_ack = 1; mem_rdata = 16'h2468;
        tick();
        mem_ack = 0;
        check("t5_rdata", rdata, 16'h2468);
        tick();
        check("t5_ndone", n_done - done_base, 1);

        // bus drive
        mdoe = 1;
        #1;
        check("bus_drive", bus, 16'h2468);
        mdoe = 0; tb_drv_en = 1; tb_drv = 16'h4110;
        #1;
        check("bus_release", bus, 16'h4110);
        tb_drv_en = 0;
        tick();

`ifdef MAU_TIMEOUT_EN
        // 6: timeout
        done_base = n_done;
        so = 16'h0000; mo = 16'h0040; rd_req = 1;
        tick();
        rd_req = 0;
        req_hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_req) req_hi++;
            tick();
        end
        check("t6_req_cycles", req_hi, 4);
        check("t6_fault", fault, 1);
        check("t6_busy", busy, 0);
        check("t6_no_done", n_done - done_base, 0);
        check("t6_rdata_keep", rdata, 16'h2468);
        tick();
        check("t6_fault_sticky", fault, 1);
        rd_req = 1;
        tick();
        rd_req = 0;
        check("t6_fault_clr", fault, 0);
        mem_ack = 1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 0;
        check("t6_done", done, 1);
        tick();
        mdoe = 1;
        #1;
        check("t6_bus", bus, 16'hBEEF);
        mdoe = 0;
        tick();
`else
        // without timeout the unit waits indefinitely
        so = 16'h0000; mo = 16'h0040; rd_req = 1;
        tick();
        rd_req = 0;
        for (int i = 0; i < 300; i++) tick();
        check("wait_forever_req", mem_req, 1);
        check("wait_forever_fault", fault, 0);
        mem_ack = 1; mem_rdata = 16'h0F0F;
        tick();
        mem_ack = 0;
        check("wait_forever_done", done, 1);
        check("wait_forever_rdata", rdata, 16'h0F0F);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
